mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/pipeline_pkg.sv | 16 +
 rtl/cond_eval.sv | 23 ++
 rtl/mem_stage.sv | 83 ++++++++
 tb/tb_mem_stage.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared control-bundle bit indices, condition codes and MEM FSM encoding
package pipeline_pkg;
  localparam int SIG_MEM_READ   = 5;
  localparam int SIG_MEM_WRITE  = 6;
  localparam int SIG_REG_WRITE  = 7;
  localparam int SIG_IS_BRANCH  = 8;
  localparam int SIG_MEM_TO_REG = 9;
  localparam logic [3:0] CC_EQ = 4'b0000;
  localparam logic [3:0] CC_NE = 4'b0001;
  localparam logic [3:0] CC_LT = 4'b0010;
  localparam logic [3:0] CC_GE = 4'b0011;
  localparam logic [3:0] CC_GT = 4'b0100;
  localparam logic [3:0] CC_LE = 4'b0101;
  localparam logic [3:0] CC_AL = 4'b1110;
  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_e;
endpackage

// File: rtl/cond_eval.sv
// cond_eval: evaluates a branch condition code against NZCV flags
module cond_eval
  import pipeline_pkg::*;
(
  input  logic [3:0] flags,
  input  logic [3:0] br_cond,
  output logic       take
);
  logic n, z, unused_c, v;
  assign {n, z, unused_c, v} = flags;
  // condition table; unlisted codes never take
  always_comb
    case (br_cond)
      CC_EQ:   take = z;
      CC_NE:   take = ~z;
      CC_LT:   take = n ^ v;
      CC_GE:   take = ~(n ^ v);
      CC_GT:   take = ~z & ~(n ^ v);
      CC_LE:   take = z | (n ^ v);
      CC_AL:   take = 1'b1;
      default: take = 1'b0;
    endcase
endmodule

// File: rtl/mem_stage.sv
// mem_stage: pipeline MEM stage with stalling data-memory handshake; MEM_STAGE_TIMEOUT_EN adds a wait timeout with sticky mem_err
module mem_stage
  import pipeline_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] alu_result,
  input  logic [31:0] write_data,
  input  logic [3:0]  rd_in,
  input  logic [3:0]  flags,
  input  logic [3:0]  br_cond,
  input  logic [31:0] new_pc,
  input  logic [10:0] signals,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic        stall,
  output logic        pc_src,
  output logic [31:0] branch_target,
  output logic [3:0]  mem_rd,
  output logic [31:0] mem_data,
  output logic        wb_mem,
  output logic [3:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_en,
  output logic        mem_err
);
  logic mem_read, mem_write, reg_write, is_branch, mem_to_reg, take, abort, bubble, unused;
  state_e state;
  assign mem_read   = signals[SIG_MEM_READ];
  assign mem_write  = signals[SIG_MEM_WRITE];
  assign reg_write  = signals[SIG_REG_WRITE];
  assign is_branch  = signals[SIG_IS_BRANCH];
  assign mem_to_reg = signals[SIG_MEM_TO_REG];
  assign unused     = ^{signals[10], signals[4:0], TIMEOUT_CYCLES > 0};
  assign dmem_req      = ~reset & ((state == S_WAIT) | mem_read | mem_write);
  assign dmem_we       = mem_write;
  assign dmem_addr     = alu_result;
  assign dmem_wdata    = write_data;
  assign stall         = dmem_req & ~dmem_ready & ~abort;
  assign bubble        = stall | abort;
  assign pc_src        = ~reset & ~stall & is_branch & take;
  assign branch_target = new_pc;
  assign mem_rd        = rd_in;
  assign mem_data      = alu_result;
  assign wb_mem        = reg_write & ~mem_to_reg;
  cond_eval u_cond (.flags(flags), .br_cond(br_cond), .take(take));
  // FSM plus MEM/WB latch; bubbles on stall or abort
  always_ff @(posedge clk)
    if (reset) begin
      state   <= S_IDLE;
      wb_rd   <= '0;
      wb_data <= '0;
      wb_en   <= 1'b0;
    end else begin
      state   <= stall ? S_WAIT : S_IDLE;
      wb_rd   <= bubble ? '0 : rd_in;
      wb_en   <= ~bubble & reg_write;
      wb_data <= bubble ? '0 : (mem_to_reg ? dmem_rdata : alu_result);
    end
`ifdef MEM_STAGE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  assign abort = (state == S_WAIT) & ~dmem_ready & (cnt == CW'(TIMEOUT_CYCLES - 1));
  // counts WAIT cycles and latches a sticky error on timeout
  always_ff @(posedge clk)
    if (reset) begin
      cnt     <= '0;
      mem_err <= 1'b0;
    end else begin
      cnt     <= (state == S_WAIT && stall) ? cnt + 1'b1 : '0;
      mem_err <= mem_err | abort;
    end
`else
  assign abort   = 1'b0;
  assign mem_err = 1'b0;
`endif
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed and randomized checks of mem_stage against a transaction-level model
module tb_mem_stage;
  logic clk = 1'b0, reset;
  logic [31:0] alu_result, write_data, new_pc, dmem_rdata;
  logic [3:0] rd_in, flags, br_cond;
  logic [10:0] signals;
  logic dmem_ready;
  logic dmem_req, dmem_we, stall, pc_src, wb_mem, wb_en, mem_err;
  logic [31:0] dmem_addr, dmem_wdata, branch_target, mem_data, wb_data;
  logic [3:0] mem_rd, wb_rd;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .reset(reset), .alu_result(alu_result), .write_data(write_data), .rd_in(rd_in),
    .flags(flags), .br_cond(br_cond), .new_pc(new_pc), .signals(signals), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_ready(dmem_ready), .stall(stall), .pc_src(pc_src), .branch_target(branch_target),
    .mem_rd(mem_rd), .mem_data(mem_data), .wb_mem(wb_mem), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_en(wb_en), .mem_err(mem_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit cond_ok(input logic [3:0] f, input logic [3:0] c);
    bit n = f[3], z = f[2], v = f[0];
    case (c)
      4'd0:    return z;
      4'd1:    return !z;
      4'd2:    return n != v;
      4'd3:    return n == v;
      4'd4:    return !z && n == v;
      4'd5:    return z || n != v;
      4'd14:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [10:0] mk(input bit mr, mw, rw, br, m2r);
    logic [10:0] s = 11'($urandom);
    s[5] = mr; s[6] = mw; s[7] = rw; s[8] = br; s[9] = m2r;
    return s;
  endfunction

  task automatic op(input logic [10:0] s, input logic [31:0] alu, wd, input logic [3:0] rd,
                    input logic [3:0] fl, bc, input logic [31:0] np, input int lat, input logic [31:0] rdv);
    bit mr = s[5], mw = s[6], rw = s[7], br = s[8], m2r = s[9];
    bit mem = mr | mw;
    int l = mem ? lat : 0;
    signals = s; alu_result = alu; write_data = wd; rd_in = rd; flags = fl; br_cond = bc; new_pc = np;
    for (int c = 0; c <= l; c++) begin
      bit st = (c < l);
      dmem_ready = !st;
      dmem_rdata = st ? $urandom : rdv;
      #1;
      chk("stall", stall, st);
      chk("dmem_req", dmem_req, mem);
      chk("dmem_we", dmem_we, mw);
      chk("dmem_addr", dmem_addr, alu);
      chk("dmem_wdata", dmem_wdata, wd);
      chk("pc_src", pc_src, br && cond_ok(fl, bc) && !st);
      chk("branch_target", branch_target, np);
      chk("mem_rd", mem_rd, rd);
      chk("mem_data", mem_data, alu);
      chk("wb_mem", wb_mem, rw && !m2r);
      @(posedge clk); #1;
      chk("wb_en", wb_en, st ? 1'b0 : rw);
      chk("wb_rd", wb_rd, st ? 4'd0 : rd);
      chk("wb_data", wb_data, st ? 32'd0 : (m2r ? rdv : alu));
      chk("mem_err", mem_err, 1'b0);
    end
  endtask

  initial begin
    reset = 1'b1; signals = mk(1, 1, 1, 1, 0); br_cond = 4'b1110; flags = 4'h0;
    alu_result = $urandom; write_data = $urandom; rd_in = 4'hf; new_pc = $urandom;
    dmem_ready = 1'b0; dmem_rdata = $urandom;
    #1;
    chk("rst_dmem_req", dmem_req, 1'b0);
    chk("rst_stall", stall, 1'b0);
    chk("rst_pc_src", pc_src, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    chk("rst_wb_en", wb_en, 1'b0);
    chk("rst_wb_rd", wb_rd, 4'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_mem_err", mem_err, 1'b0);
    reset = 1'b0;
    op(mk(1, 0, 1, 0, 1), 32'h10, 32'h0, 4'd3, 4'h0, 4'h0, 32'h0, 0, 32'hDEADBEEF);
    op(mk(0, 1, 0, 0, 0), 32'h200, 32'hCAFEF00D, 4'd1, 4'h0, 4'h0, 32'h0, 3, 32'h0);
    op(mk(0, 0, 0, 1, 0), 32'h0, 32'h0, 4'd0, 4'b1000, 4'b0010, 32'h40, 0, 32'h0);
    op(mk(0, 0, 0, 1, 0), 32'h0, 32'h0, 4'd0, 4'b1001, 4'b0010, 32'h40, 0, 32'h0);
    op(mk(0, 0, 1, 0, 0), 32'd7, 32'h0, 4'd5, 4'h0, 4'h0, 32'h0, 0, 32'h0);
    op(mk(1, 1, 0, 0, 0), 32'h88, 32'h1234, 4'd2, 4'h0, 4'h0, 32'h0, 1, 32'h5555);
    op(mk(0, 0, 0, 1, 0), 32'h0, 32'h0, 4'd0, 4'h0, 4'b0111, 32'h80, 0, 32'h0);
    // reset while waiting abandons the access
    signals = mk(1, 0, 1, 0, 1); dmem_ready = 1'b0; alu_result = 32'h30; rd_in = 4'd9;
    #1; chk("pre_wait_stall", stall, 1'b1);
    @(posedge clk); #1;
    chk("wait_req", dmem_req, 1'b1);
    reset = 1'b1; signals = mk(1, 0, 1, 1, 1); br_cond = 4'b1110;
    #1;
    chk("rstwait_req", dmem_req, 1'b0);
    chk("rstwait_stall", stall, 1'b0);
    chk("rstwait_pc_src", pc_src, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0; signals = mk(0, 0, 0, 0, 0);
    #1;
    chk("post_rst_req", dmem_req, 1'b0);
    chk("post_rst_wb_en", wb_en, 1'b0);
    @(posedge clk); #1;
    // memory never answers
    signals = mk(1, 0, 1, 0, 1); dmem_ready = 1'b0; rd_in = 4'd4; alu_result = 32'h44;
`ifdef MEM_STAGE_TIMEOUT_EN
    for (int c = 0; c <= 16; c++) begin
      #1;
      chk("to_stall", stall, c < 16);
      @(posedge clk); #1;
      chk("to_wb_en", wb_en, 1'b0);
      chk("to_mem_err", mem_err, c == 16);
    end
    signals = mk(0, 0, 0, 0, 0);
    repeat (5) @(posedge clk);
    #1; chk("to_sticky", mem_err, 1'b1);
    reset = 1'b1; @(posedge clk); #1; reset = 1'b0;
    chk("to_cleared", mem_err, 1'b0);
`else
    for (int c = 0; c < 40; c++) begin
      #1;
      chk("inf_stall", stall, 1'b1);
      @(posedge clk); #1;
      chk("inf_wb_en", wb_en, 1'b0);
      chk("inf_mem_err", mem_err, 1'b0);
    end
    op(signals, 32'h44, write_data, 4'd4, 4'h0, 4'h0, 32'h0, 0, 32'h600D);
`endif
    for (int i = 0; i < 300; i++) begin
      logic [10:0] s = mk($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                          $urandom_range(0, 1), $urandom_range(0, 1));
      op(s, $urandom, $urandom, 4'($urandom), 4'($urandom), 4'($urandom), $urandom,
         $urandom_range(0, 3), $urandom);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
